// File: rtl/jtag_pkg.sv
// jtag_pkg: shared TAP state encoding, opcodes and IR capture value.
// Used by jtag_tap_fsm and jtag_bscan_ctrl (JTAG_IDCODE_EN gates the IDCODE register).
package jtag_pkg;

   // Conventional 4-bit TAP state encodings
   typedef enum logic [3:0] {
      EX2_DR   = 4'h0,
      EX1_DR   = 4'h1,
      SH_DR    = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EX2_IR   = 4'h8,
      EX1_IR   = 4'h9,
      SH_IR    = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_t;

   localparam logic [1:0] OP_EXTEST  = 2'b00;
   localparam logic [1:0] OP_SAMPLE  = 2'b01;
   localparam logic [1:0] OP_IDCODE  = 2'b10;
   localparam logic [1:0] OP_BYPASS  = 2'b11;

   // Fixed pattern captured into the IR shift stage; LSB 1 lets a host find IR length
   localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: bare 16-state TAP controller, state registered on rising TCK.
// No outputs other than the state so other TAP clients can reuse it.
module jtag_tap_fsm
   import jtag_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_tms,
   output tap_state_t state
);

   // Standard TMS-driven transitions; five TMS=1 edges always land in TLR
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= TLR;
      end else begin
         case (state)
            TLR:      state <= i_tms ? TLR    : RTI;
            RTI:      state <= i_tms ? SEL_DR : RTI;
            SEL_DR:   state <= i_tms ? SEL_IR : CAP_DR;
            CAP_DR:   state <= i_tms ? EX1_DR : SH_DR;
            SH_DR:    state <= i_tms ? EX1_DR : SH_DR;
            EX1_DR:   state <= i_tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state <= i_tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   state <= i_tms ? UPD_DR : SH_DR;
            UPD_DR:   state <= i_tms ? SEL_DR : RTI;
            SEL_IR:   state <= i_tms ? TLR    : CAP_IR;
            CAP_IR:   state <= i_tms ? EX1_IR : SH_IR;
            SH_IR:    state <= i_tms ? EX1_IR : SH_IR;
            EX1_IR:   state <= i_tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state <= i_tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   state <= i_tms ? UPD_IR : SH_IR;
            UPD_IR:   state <= i_tms ? SEL_DR : RTI;
            default:  state <= TLR;
         endcase
      end
   end

endmodule

// File: rtl/jtag_bscan_ctrl.sv
// jtag_bscan_ctrl: TAP front end for a boundary-scan chain. Holds IR, bypass
// and (when JTAG_IDCODE_EN is defined) a 32-bit IDCODE register, and decodes
// chain shift enable, drive permission and the TDO return mux.
module jtag_bscan_ctrl
   import jtag_pkg::*;
#(
   parameter int          IR_WIDTH   = 2,
   parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
)(
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_tms,
   input  logic i_tdi,
   output logic o_tdo,
   output logic o_tdoEn,
   output logic o_chainShiftIn,
   input  logic i_chainShiftOut,
   output logic o_doShift,
   output logic o_canDrive
);

`ifdef JTAG_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] IR_RESET = OP_IDCODE;
`else
   localparam logic [IR_WIDTH-1:0] IR_RESET = OP_BYPASS;
`endif

   tap_state_t          state;
   logic [IR_WIDTH-1:0] ir_shift;
   logic [IR_WIDTH-1:0] ir;
   logic                bypass_reg;
   logic                chain_sel;
   logic                idcode_sel;
   logic                idcode_lsb;

   jtag_tap_fsm u_fsm (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_tms  (i_tms),
      .state  (state)
   );

   // IR shift stage: capture fixed pattern, shift right with TDI into MSB
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)             ir_shift <= IR_CAPTURE;
      else if (state == CAP_IR) ir_shift <= IR_CAPTURE;
      else if (state == SH_IR)  ir_shift <= {i_tdi, ir_shift[IR_WIDTH-1:1]};
   end

   // IR update: only committed on the edge leaving UpdIR, reloaded while in TLR
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)              ir <= IR_RESET;
      else if (state == TLR)    ir <= IR_RESET;
      else if (state == UPD_IR) ir <= ir_shift;
   end

   // Bypass bit: captures 0 so a host sees a leading zero per bypassed device
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)              bypass_reg <= 1'b0;
      else if (state == CAP_DR) bypass_reg <= 1'b0;
      else if (state == SH_DR)  bypass_reg <= i_tdi;
   end

`ifdef JTAG_IDCODE_EN
   logic [31:0] idcode_reg;

   // IDCODE: capture the constant, shift out LSB first
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)              idcode_reg <= IDCODE_VAL;
      else if (state == CAP_DR) idcode_reg <= IDCODE_VAL;
      else if (state == SH_DR)  idcode_reg <= {i_tdi, idcode_reg[31:1]};
   end

   assign idcode_sel = (ir == OP_IDCODE);
   assign idcode_lsb = idcode_reg[0];
`else
   // Opcode 10 falls through to bypass when there is no IDCODE register
   assign idcode_sel = 1'b0;
   assign idcode_lsb = 1'b0;
   wire   unused_idcode = ^IDCODE_VAL;
`endif

   assign chain_sel      = (ir == OP_EXTEST) || (ir == OP_SAMPLE);
   assign o_chainShiftIn = i_tdi;
   assign o_tdoEn        = (state == SH_IR) || (state == SH_DR);
   assign o_doShift      = (state == SH_DR) && chain_sel;
   // Chain masks its own drivers while shifting, so no ShDR gating here
   assign o_canDrive     = (ir == OP_EXTEST) && (state != TLR);

   // TDO return mux, forced low outside the shift states
   always_comb begin
      o_tdo = 1'b0;
      case (state)
         SH_IR: o_tdo = ir_shift[0];
         SH_DR: begin
            if (chain_sel)       o_tdo = i_chainShiftOut;
            else if (idcode_sel) o_tdo = idcode_lsb;
            else                 o_tdo = bypass_reg;
         end
         default: o_tdo = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_jtag_bscan_ctrl.sv
// tb_jtag_bscan_ctrl: directed vectors for jtag_bscan_ctrl, with a 4-cell
// chain model. Expectations follow JTAG_IDCODE_EN when it is defined.
module tb_jtag_bscan_ctrl;
   import jtag_pkg::*;

   logic i_clk, i_rstn, i_tms, i_tdi;
   logic o_tdo, o_tdoEn, o_chainShiftIn, i_chainShiftOut, o_doShift, o_canDrive;

   logic [3:0]  chain;
   logic [3:0]  chain_init;
   logic        chain_load;
   int          shift_cnt;
   int          n_chk, n_fail;

`ifdef JTAG_IDCODE_EN
   localparam logic        RST_DR_BIT = 1'b1;            // IDCODE LSB
   localparam logic [31:0] EXP_ID     = 32'hA5A5_0001;
`else
   localparam logic        RST_DR_BIT = 1'b0;            // bypass capture
   localparam logic [31:0] EXP_ID     = 32'hFFFF_FFFE;   // 0 then TDI=1s
`endif

   jtag_bscan_ctrl #(.IR_WIDTH(2), .IDCODE_VAL(32'hA5A5_0001)) dut (
      .i_clk           (i_clk),
      .i_rstn          (i_rstn),
      .i_tms           (i_tms),
      .i_tdi           (i_tdi),
      .o_tdo           (o_tdo),
      .o_tdoEn         (o_tdoEn),
      .o_chainShiftIn  (o_chainShiftIn),
      .i_chainShiftOut (i_chainShiftOut),
      .o_doShift       (o_doShift),
      .o_canDrive      (o_canDrive)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // 4-cell chain: head takes chain serial-in, tail returns on bit 0
   assign i_chainShiftOut = chain[0];
   always @(posedge i_clk) begin
      if (chain_load)     chain <= chain_init;
      else if (o_doShift) chain <= {o_chainShiftIn, chain[3:1]};
   end

   initial shift_cnt = 0;
   always @(posedge i_clk) if (o_doShift) shift_cnt <= shift_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic tms, input logic tdi);
      i_tms = tms;
      i_tdi = tdi;
      @(posedge i_clk);
      #1;
   endtask

   // RTI -> ShIR, shift op, UpdIR -> RTI; TDO must show captured 01 LSB first
   task automatic load_ir(input logic [1:0] op);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      chk("ir_tdoen", 32'(o_tdoEn), 1);
      chk("ir_tdo0", 32'(o_tdo), 1);
      step(0, op[0]);
      chk("ir_tdo1", 32'(o_tdo), 0);
      step(1, op[1]); step(1, 0); step(0, 0);
   endtask

   // RTI -> SelDR -> CapDR -> ShDR
   task automatic to_shdr();
      step(1, 0); step(0, 0); step(0, 0);
   endtask

   logic [31:0] got;
   logic [3:0]  tdi4;
   int          cnt0;

   initial begin
      n_chk = 0; n_fail = 0;
      chain_load = 1'b0; chain_init = 4'b1010;
      i_rstn = 1'b0; i_tms = 1'b1; i_tdi = 1'b0;
      #12;
      chk("rst_tdo",   32'(o_tdo), 0);
      chk("rst_tdoen", 32'(o_tdoEn), 0);
      chk("rst_shift", 32'(o_doShift), 0);
      chk("rst_drive", 32'(o_canDrive), 0);
      chk("rst_state", 32'(dut.state), 32'(TLR));
      i_rstn = 1'b1;
      step(0, 0);                                    // RTI

      // EXTEST: drive allowed in RTI and ShDR, then TMS=1 x5 back to TLR
      load_ir(2'b00);
      chk("ext_drive_rti", 32'(o_canDrive), 1);
      to_shdr();
      chk("ext_doshift", 32'(o_doShift), 1);
      chk("ext_drive_sh", 32'(o_canDrive), 1);
      for (int k = 0; k < 5; k++) step(1, 0);
      chk("tlr_state", 32'(dut.state), 32'(TLR));
      chk("tlr_drive", 32'(o_canDrive), 0);
      chk("tlr_doshift", 32'(o_doShift), 0);
      step(0, 0);                                    // RTI, IR reloaded
      chk("tlr_ir_drive", 32'(o_canDrive), 0);
      to_shdr();
      chk("tlr_ir_dr", 32'(o_tdo), 32'(RST_DR_BIT));
      step(1, 0); step(1, 0); step(0, 0);

      // SAMPLE against the chain model: chain 1010 out, TDI 1,1,0,0 in
      load_ir(2'b01);
      chk("smp_drive", 32'(o_canDrive), 0);
      chain_load = 1'b1; step(0, 0); chain_load = 1'b0;
      cnt0 = shift_cnt;
      to_shdr();
      tdi4 = 4'b0011;
      got  = '0;
      for (int k = 0; k < 4; k++) begin
         chk("smp_doshift", 32'(o_doShift), 1);
         got[k] = o_tdo;
         step(k == 3, tdi4[k]);
      end
      chk("smp_tdo", got, 32'h0000_000A);
      chk("smp_ex1_shift", 32'(o_doShift), 0);
      step(1, 0); step(0, 0);
      chk("smp_edges", 32'(shift_cnt - cnt0), 4);
      chk("smp_chain", 32'(chain), 32'h3);

      // BYPASS: TDI 1,0,1,1 returns 0,1,0,1
      load_ir(2'b11);
      to_shdr();
      tdi4 = 4'b1101;
      got  = '0;
      for (int k = 0; k < 4; k++) begin
         got[k] = o_tdo;
         step(k == 3, tdi4[k]);
      end
      chk("byp_tdo", got, 32'h0000_000A);
      chk("byp_ex1_tdoen", 32'(o_tdoEn), 0);
      step(1, 0); step(0, 0);

      // IDCODE (or bypass fallback): 32 shifts with TDI=1
      load_ir(2'b10);
      chk("id_drive", 32'(o_canDrive), 0);
      to_shdr();
      chk("id_doshift", 32'(o_doShift), 0);
      got = '0;
      for (int k = 0; k < 32; k++) begin
         got[k] = o_tdo;
         step(k == 31, 1);
      end
      chk("id_tdo", got, EXP_ID);
      step(1, 0); step(0, 0);

      // Async reset one bit into ShIR discards IR state
      load_ir(2'b00);
      chk("pre_rst_drive", 32'(o_canDrive), 1);
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
      step(0, 0);
      chk("mid_tdoen", 32'(o_tdoEn), 1);
      #2 i_rstn = 1'b0;
      #1;
      chk("mid_state", 32'(dut.state), 32'(TLR));
      chk("mid_tdo",   32'(o_tdo), 0);
      chk("mid_tdoen0", 32'(o_tdoEn), 0);
      chk("mid_drive", 32'(o_canDrive), 0);
      chk("mid_doshift", 32'(o_doShift), 0);
      #1 i_rstn = 1'b1;
      step(0, 0);
      chk("post_drive", 32'(o_canDrive), 0);
      to_shdr();
      chk("post_ir_dr", 32'(o_tdo), 32'(RST_DR_BIT));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
